cursor_paint_ctrl: RTL
======================

Name: cursor_paint_ctrl

Overview:
Parametrised cursor controller and painter for the VGA frame-buffer path. Synchronises and debounces four active-low direction buttons, moves a SIZE×SIZE cursor in STEP increments with auto-repeat and edge clamping, and emits a combinational overlay hit for the scan-out pixel. Drives the shared RGB frame-buffer write port: a full-screen clear after reset, and, in paint mode, a SIZE×SIZE stamp of the cell the cursor just left.

Parameters:
W_RES, 640, visible width in pixels
H_RES, 480, visible height in pixels
SIZE, 16, cursor edge length in pixels
STEP, 16, pixels moved per step
DIVISOR, 200000, VGA_CLK cycles per tick; must exceed SIZE*SIZE+4
DEBOUNCE, 4, consecutive low-sampled ticks before a press is accepted
REPEAT, 8, ticks between auto-repeat steps while a button is held
COORD_W, 11, coordinate width
COLOR_W, 8, per-channel colour width
CLEAR_COLOR, 24'hFFFFFF, RGB value written during clear

Ports:
VGA_CLK  in  1  clock
reset  in  1  synchronous active-low reset
up_n, down_n, left_n, right_n  in  1 each  raw active-low buttons, asynchronous
paint_mode  in  1  level; 1 = stamp the cell vacated on each move
color_in  in  3*COLOR_W  {R,G,B} stamp colour, latched at move commit
pix_x, pix_y  in  COORD_W each  current scan-out coordinate
cursor_x, cursor_y  out  COORD_W each  cursor top-left, registered
cursor_hit  out  1  pix inside cursor, combinational
wr_en  out  1  frame-buffer write strobe
wr_x, wr_y  out  COORD_W each  write coordinate
wr_data  out  3*COLOR_W  write RGB
busy  out  1  high in CLEAR or STAMP

Behaviour:
- Reset (reset=0 at a VGA_CLK edge): cursor_x=(W_RES-SIZE)/2, cursor_y=(H_RES-SIZE)/2; tick counter, debounce and repeat counters =0; synchronisers =1; FSM=CLEAR_INIT; wr_en=0, wr_x=wr_y=0, wr_data=0, busy=0. Reset asserted mid-operation aborts any clear or stamp the same cycle.
- Tick: counter runs 0..DIVISOR-1 and wraps. tick pulses for one cycle when counter==DIVISOR-1.
- Buttons: two-flop synchroniser each, sampled only on tick. Per-button counter increments on a low sample, saturates at DEBOUNCE, and clears on a high sample. Button is pressed when its counter==DEBOUNCE.
- Direction select: priority up>down>left>right among pressed buttons. A step is requested on the first tick a button becomes pressed. While the same direction stays selected, a further step is requested every REPEAT ticks. A direction change restarts the repeat count. No pressed button gives no step.
- Step commit occurs in the cycle after tick, only in IDLE; a request arriving while busy=1 is dropped.
  - up: y = (y<STEP) ? 0 : y-STEP
  - down: y = (y+STEP > H_RES-SIZE) ? H_RES-SIZE : y+STEP
  - left / right: same rules on x with W_RES.
  - All arithmetic is COORD_W+1 wide to avoid wrap.
- A clamped step that leaves the position unchanged is not a move and triggers no stamp.
- FSM states and transitions:
  - CLEAR_INIT: entered from reset. Goes to CLEAR on the first cycle with reset=1.
  - CLEAR: wr_en=1, wr_data=CLEAR_COLOR. wr_x/wr_y sweep raster order from (0,0) to (W_RES-1,H_RES-1), one pixel per cycle. Step commits are blocked. After the last pixel goes to IDLE, so W_RES*H_RES write cycles.
  - IDLE: wr_en=0, busy=0. On a real move with paint_mode=1, latches the old cursor_x/y and color_in, then goes to STAMP.
  - STAMP: wr_en=1, wr_data=latched colour. Writes rows old_y..old_y+SIZE-1, each row x from old_x..old_x+SIZE-1, one write per cycle, so SIZE*SIZE cycles. The first write is in the cycle after commit. Returns to IDLE after the last write. paint_mode changes during STAMP do not abort it.
- busy = (state==CLEAR || state==STAMP), registered with the state.
- cursor_hit = pix_x∈[cursor_x, cursor_x+SIZE-1] AND pix_y∈[cursor_y, cursor_y+SIZE-1]. Exactly SIZE pixels per axis.

Test Plan:
Params for all scenarios: W_RES=64, H_RES=48, SIZE=4, STEP=4, DIVISOR=32, DEBOUNCE=2, REPEAT=3.
1. Reset low 3 cycles then release -> cursor=(30,22); wr_en high for exactly 3072 consecutive cycles; writes run (0,0),(1,0)…(63,47) with data FFFFFF; then busy=0.
2. After clear, hold up_n=0 for 2 ticks then release -> exactly one step at the cycle after the 2nd tick, cursor_y=18; a 1-tick glitch on down_n gives no move.
3. Hold right_n=0 for 12 ticks -> x steps 34, then 38, 42, 46 at 3-tick intervals; then force x=58 by further holding -> clamps at 60; further ticks make no change and no stamp.
4. paint_mode=1, color_in=0x00FF00, cursor (30,22), press left -> cursor_x=26; 16 writes (30..33,22..25) row-major with data 00FF00, first one cycle after the commit; busy high for 16 cycles.
5. Press up and left together, same tick -> only y changes. Press down while busy -> that step dropped, cursor unchanged.
6. Reset low mid-STAMP (write 7) -> wr_en=0 and cursor=(30,22) the next cycle; a full clear restarts after release. Scan pix=(33,25) -> cursor_hit=1; pix=(34,22) -> cursor_hit=0.

Source files
------------

// File: rtl/cursor_paint_ctrl.sv
// Cursor controller and painter: debounced buttons move a SIZE x SIZE cursor with auto-repeat,
// and the frame-buffer write port is driven for the power-up clear and for paint-mode stamps.
module cursor_paint_ctrl #(
   parameter int unsigned W_RES    = 640,
   parameter int unsigned H_RES    = 480,
   parameter int unsigned SIZE     = 16,
   parameter int unsigned STEP     = 16,
   parameter int unsigned DIVISOR  = 200000,
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned REPEAT   = 8,
   parameter int unsigned COORD_W  = 11,
   parameter int unsigned COLOR_W  = 8,
   parameter logic [3*COLOR_W-1:0] CLEAR_COLOR = 24'hFFFFFF
) (
   input  logic                   VGA_CLK,
   input  logic                   reset,
   input  logic                   up_n,
   input  logic                   down_n,
   input  logic                   left_n,
   input  logic                   right_n,
   input  logic                   paint_mode,
   input  logic [3*COLOR_W-1:0]   color_in,
   input  logic [COORD_W-1:0]     pix_x,
   input  logic [COORD_W-1:0]     pix_y,
   output logic [COORD_W-1:0]     cursor_x,
   output logic [COORD_W-1:0]     cursor_y,
   output logic                   cursor_hit,
   output logic                   wr_en,
   output logic [COORD_W-1:0]     wr_x,
   output logic [COORD_W-1:0]     wr_y,
   output logic [3*COLOR_W-1:0]   wr_data,
   output logic                   busy
);

   localparam int unsigned TICK_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
   localparam int unsigned REP_W  = $clog2(REPEAT + 1);
   localparam int unsigned CW1    = COORD_W + 1;

   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(DIVISOR - 1);
   localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DEBOUNCE);
   localparam logic [REP_W-1:0]   REP_LAST  = REP_W'(REPEAT - 1);
   localparam logic [CW1-1:0]     STEP_E    = CW1'(STEP);
   localparam logic [CW1-1:0]     MAX_X     = CW1'(W_RES - SIZE);
   localparam logic [CW1-1:0]     MAX_Y     = CW1'(H_RES - SIZE);
   localparam logic [CW1-1:0]     SIZE_M1_E = CW1'(SIZE - 1);
   localparam logic [COORD_W-1:0] SIZE_M1   = COORD_W'(SIZE - 1);
   localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(W_RES - 1);
   localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] HOME_X    = COORD_W'((W_RES - SIZE) / 2);
   localparam logic [COORD_W-1:0] HOME_Y    = COORD_W'((H_RES - SIZE) / 2);

   localparam logic [1:0] CLEAR_INIT = 2'd0;
   localparam logic [1:0] CLEAR      = 2'd1;
   localparam logic [1:0] IDLE       = 2'd2;
   localparam logic [1:0] STAMP      = 2'd3;

   // Direction codes double as button indices; higher index wins.
   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_UP    = 2'd3;

   logic [TICK_W-1:0]  tick_cnt_q;
   logic               tick;
   logic [3:0]         sync1_q, sync2_q;
   logic [DB_W-1:0]    db_q [4];
   logic [DB_W-1:0]    db_d [4];
   logic [3:0]         pressed_d;
   logic               sel_valid;
   logic [1:0]         sel_dir;
   logic               dir_valid_q, dir_valid_d;
   logic [1:0]         dir_q, dir_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic               step_d, step_req_q;
   logic [1:0]         step_dir_q;
   logic [CW1-1:0]     ext_x, ext_y, sum_x, sum_y, new_x, new_y;
   logic [CW1-1:0]     pix_x_e, pix_y_e;
   logic               moved;
   logic [1:0]         state_q;
   logic [COORD_W-1:0] stamp_x0_q, stamp_y0_q;

   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         tick_cnt_q <= '0;
         sync1_q    <= '1;
         sync2_q    <= '1;
      end else begin
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         sync1_q    <= {up_n, down_n, left_n, right_n};
         sync2_q    <= sync1_q;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i]) begin
            db_d[i] = '0;
         end else if (db_q[i] == DB_MAX) begin
            db_d[i] = DB_MAX;
         end else begin
            db_d[i] = db_q[i] + 1'b1;
         end
         pressed_d[i] = (db_d[i] == DB_MAX);
      end
   end

   always_comb begin
      sel_valid = |pressed_d;
      sel_dir   = DIR_RIGHT;
      for (int i = 0; i < 4; i++) begin
         if (pressed_d[i]) sel_dir = 2'(i);
      end
   end

   // A newly selected direction steps at once; a held one steps every REPEAT ticks.
   always_comb begin
      step_d      = 1'b0;
      rep_d       = rep_q;
      dir_d       = dir_q;
      dir_valid_d = dir_valid_q;
      if (tick) begin
         if (!sel_valid) begin
            rep_d       = '0;
            dir_valid_d = 1'b0;
         end else if (!dir_valid_q || (sel_dir != dir_q)) begin
            step_d      = 1'b1;
            rep_d       = '0;
            dir_d       = sel_dir;
            dir_valid_d = 1'b1;
         end else if (rep_q == REP_LAST) begin
            step_d = 1'b1;
            rep_d  = '0;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) db_q[i] <= '0;
         dir_valid_q <= 1'b0;
         dir_q       <= DIR_RIGHT;
         rep_q       <= '0;
         step_req_q  <= 1'b0;
         step_dir_q  <= DIR_RIGHT;
      end else begin
         if (tick) begin
            for (int i = 0; i < 4; i++) db_q[i] <= db_d[i];
         end
         dir_valid_q <= dir_valid_d;
         dir_q       <= dir_d;
         rep_q       <= rep_d;
         step_req_q  <= step_d;
         step_dir_q  <= dir_d;
      end
   end

   assign ext_x   = {1'b0, cursor_x};
   assign ext_y   = {1'b0, cursor_y};
   assign sum_x   = ext_x + STEP_E;
   assign sum_y   = ext_y + STEP_E;
   assign pix_x_e = {1'b0, pix_x};
   assign pix_y_e = {1'b0, pix_y};

   always_comb begin
      new_x = ext_x;
      new_y = ext_y;
      case (step_dir_q)
         DIR_UP:   new_y = (ext_y < STEP_E) ? '0 : ext_y - STEP_E;
         DIR_DOWN: new_y = (sum_y > MAX_Y) ? MAX_Y : sum_y;
         DIR_LEFT: new_x = (ext_x < STEP_E) ? '0 : ext_x - STEP_E;
         default:  new_x = (sum_x > MAX_X) ? MAX_X : sum_x;
      endcase
      moved = step_req_q && (state_q == IDLE) && ((new_x != ext_x) || (new_y != ext_y));
   end

   always_comb begin
      cursor_hit = (pix_x_e >= ext_x) && (pix_x_e <= ext_x + SIZE_M1_E) &&
                   (pix_y_e >= ext_y) && (pix_y_e <= ext_y + SIZE_M1_E);
   end

   always_ff @(posedge VGA_CLK) begin
      if (!reset) begin
         state_q    <= CLEAR_INIT;
         cursor_x   <= HOME_X;
         cursor_y   <= HOME_Y;
         wr_en      <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         stamp_x0_q <= '0;
         stamp_y0_q <= '0;
      end else begin
         case (state_q)
            CLEAR_INIT: begin
               state_q <= CLEAR;
               wr_en   <= 1'b1;
               wr_x    <= '0;
               wr_y    <= '0;
               wr_data <= CLEAR_COLOR;
               busy    <= 1'b1;
            end
            CLEAR: begin
               if (wr_x == LAST_X) begin
                  wr_x <= '0;
                  if (wr_y == LAST_Y) begin
                     state_q <= IDLE;
                     wr_en   <= 1'b0;
                     busy    <= 1'b0;
                     wr_y    <= '0;
                  end else begin
                     wr_y <= wr_y + 1'b1;
                  end
               end else begin
                  wr_x <= wr_x + 1'b1;
               end
            end
            IDLE: begin
               if (moved) begin
                  cursor_x <= new_x[COORD_W-1:0];
                  cursor_y <= new_y[COORD_W-1:0];
                  if (paint_mode) begin
                     state_q    <= STAMP;
                     wr_en      <= 1'b1;
                     busy       <= 1'b1;
                     wr_x       <= cursor_x;
                     wr_y       <= cursor_y;
                     stamp_x0_q <= cursor_x;
                     stamp_y0_q <= cursor_y;
                     wr_data    <= color_in;
                  end
               end
            end
            default: begin
               if (wr_x == stamp_x0_q + SIZE_M1) begin
                  wr_x <= stamp_x0_q;
                  if (wr_y == stamp_y0_q + SIZE_M1) begin
                     state_q <= IDLE;
                     wr_en   <= 1'b0;
                     busy    <= 1'b0;
                  end else begin
                     wr_y <= wr_y + 1'b1;
                  end
               end else begin
                  wr_x <= wr_x + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
